gray_updown_counter_p: RTL and testbench

GRAY_UPDOWN_COUNTER_P -- requirements
Module: gray_updown_counter_p

---
 rtl/gray_updown_counter_p.sv | 109 ++++++++++
 tb/tb_gray_updown_counter_p.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter_p.sv
// rtl/gray_updown_counter_p.sv - Up/down Gray counter with binary, one-hot, wrap and end-point flags
// Optional registered one-hot output enabled by GRAY_COUNTER_ONEHOT_EN.
module gray_updown_counter_p #(
    parameter int BITS     = 3,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up_down,
    input  logic                 clr,
    input  logic                 load,
    input  logic [BITS-1:0]      load_gray,
    output logic [BITS-1:0]      out_gray,
    output logic [BITS-1:0]      out_bin,
    output logic [(1<<BITS)-1:0] out_hot,
    output logic                 wrap,
    output logic                 at_max,
    output logic                 at_min
);

    localparam int DEPTH = 1 << BITS;
    localparam logic [BITS-1:0] MAX_VAL = '1;

    logic [BITS-1:0] bin_q, bin_d;
    logic [BITS-1:0] gray_q, gray_d;
    logic            wrap_q, wrap_d;
    logic [BITS-1:0] load_bin;

    // Prefix XOR from the MSB down turns the Gray load value into binary.
    always_comb begin
        load_bin = '0;
        load_bin[BITS-1] = load_gray[BITS-1];
        for (int i = BITS - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_gray[i];
        end
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clr) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_down) begin
                if (bin_q == MAX_VAL) begin
                    if (SATURATE == 0) begin
                        bin_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + BITS'(1);
                end
            end else begin
                if (bin_q == '0) begin
                    if (SATURATE == 0) begin
                        bin_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - BITS'(1);
                end
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef GRAY_COUNTER_ONEHOT_EN
    logic [DEPTH-1:0] hot_q, hot_d;

    always_comb begin
        hot_d        = '0;
        hot_d[bin_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hot_q <= DEPTH'(1);
        end else begin
            hot_q <= hot_d;
        end
    end

    assign out_hot = hot_q;
`else
    assign out_hot = '0;
`endif

    assign out_bin  = bin_q;
    assign out_gray = gray_q;
    assign wrap     = wrap_q;
    assign at_max   = (bin_q == MAX_VAL);
    assign at_min   = (bin_q == '0);

endmodule

// File: tb/tb_gray_updown_counter_p.sv
// tb/tb_gray_updown_counter_p.sv - Randomized reference-model bench for gray_updown_counter_p
module tb_gray_updown_counter_p;

    logic clk = 1'b0;
    logic rst_n, en, up_down, clr, load;
    logic [3:0] lg;

    logic [2:0] g3, b3, gs, bs;
    logic [3:0] g4, b4;
    logic [7:0] h3, hs;
    logic [15:0] h4;
    logic w3_o, ws_o, w4_o, mx3, mn3, mxs, mns, mx4, mn4;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int m3, ms, m4;
    bit w3, ws, w4;
    logic [3:0] pg3, pgs, pg4;
    bit step_ev;

    always #5 clk = ~clk;

    gray_updown_counter_p #(.BITS(3), .SATURATE(0)) d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_gray(lg[2:0]), .out_gray(g3), .out_bin(b3), .out_hot(h3), .wrap(w3_o),
        .at_max(mx3), .at_min(mn3));

    gray_updown_counter_p #(.BITS(3), .SATURATE(1)) ds (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_gray(lg[2:0]), .out_gray(gs), .out_bin(bs), .out_hot(hs), .wrap(ws_o),
        .at_max(mxs), .at_min(mns));

    gray_updown_counter_p #(.BITS(4), .SATURATE(0)) d4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_gray(lg), .out_gray(g4), .out_bin(b4), .out_hot(h4), .wrap(w4_o),
        .at_max(mx4), .at_min(mn4));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Gray decode by search: the value whose Gray code matches.
    function automatic int gray2bin(int g, int bits);
        for (int b = 0; b < (1 << bits); b++)
            if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic int step(int cnt, int bits, int sat, output bit w);
        int mx;
        mx = (1 << bits) - 1;
        w = 1'b0;
        if (!rst_n || clr) return 0;
        if (load) return gray2bin(int'(lg) & mx, bits);
        if (!en) return cnt;
        if (up_down) begin
            if (cnt < mx) return cnt + 1;
            if (sat != 0) return mx;
            w = 1'b1;
            return 0;
        end
        if (cnt > 0) return cnt - 1;
        if (sat != 0) return 0;
        w = 1'b1;
        return mx;
    endfunction

    task automatic check_inst(input string nm, input int bits, input int cnt, input bit w,
                              input logic [15:0] g, input logic [15:0] b, input logic [15:0] hot,
                              input logic wo, input logic amax, input logic amin);
        int exp_hot;
`ifdef GRAY_COUNTER_ONEHOT_EN
        exp_hot = 1 << cnt;
`else
        exp_hot = 0;
`endif
        chk({nm, ".bin"}, 32'(b), 32'(cnt));
        chk({nm, ".gray"}, 32'(g), 32'(cnt ^ (cnt >> 1)));
        chk({nm, ".hot"}, 32'(hot), 32'(exp_hot));
        chk({nm, ".wrap"}, 32'(wo), 32'(w));
        chk({nm, ".at_max"}, 32'(amax), 32'(cnt == (1 << bits) - 1));
        chk({nm, ".at_min"}, 32'(amin), 32'(cnt == 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        step_ev = rst_n && !clr && !load && en;
        pg3 = {1'b0, g3}; pgs = {1'b0, gs}; pg4 = g4;
        m3 = step(m3, 3, 0, w3);
        ms = step(ms, 3, 1, ws);
        m4 = step(m4, 4, 0, w4);
        #1;
        check_inst("d3", 3, m3, w3, 16'(g3), 16'(b3), 16'(h3), w3_o, mx3, mn3);
        check_inst("ds", 3, ms, ws, 16'(gs), 16'(bs), 16'(hs), ws_o, mxs, mns);
        check_inst("d4", 4, m4, w4, 16'(g4), 16'(b4), h4, w4_o, mx4, mn4);
        if (step_ev) begin
            chk("d3.ham", 32'($countones(pg3 ^ {1'b0, g3}) <= 1), 32'd1);
            chk("ds.ham", 32'($countones(pgs ^ {1'b0, gs}) <= 1), 32'd1);
            chk("d4.ham", 32'($countones(pg4 ^ g4) <= 1), 32'd1);
        end
    endtask

    initial begin
        int seq [9];
        seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        m3 = 0; ms = 0; m4 = 0;
        rst_n = 1'b0; en = 1'b1; up_down = 1'b1; clr = 1'b1; load = 1'b1; lg = 4'h5;
        cycle();
        cycle();
        chk("rst.gray", 32'(g3), 32'd0);
        chk("rst.at_min", 32'(mn3), 32'd1);

        // Count up through a full wrap.
        rst_n = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b1; up_down = 1'b1;
        for (int i = 1; i < 9; i++) begin
            cycle();
            chk("s1.gray", 32'(g3), 32'(seq[i]));
            chk("s1.wrap", 32'(w3_o), 32'(i == 8));
        end

        // Down from zero wraps to max.
        up_down = 1'b0;
        cycle();
        chk("s2.bin", 32'(b3), 32'd7);
        chk("s2.gray", 32'(g3), 32'h4);
        chk("s2.wrap", 32'(w3_o), 32'd1);
        chk("s2.at_max", 32'(mx3), 32'd1);

        up_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("s3.bin", 32'(bs), 32'd7);
            chk("s3.wrap", 32'(ws_o), 32'd0);
            chk("s3.at_max", 32'(mxs), 32'd1);
        end

        load = 1'b1; lg = 4'b0110; en = 1'b1;
        cycle();
        chk("s4.gray", 32'(g3), 32'h6);
        chk("s4.bin", 32'(b3), 32'd4);
        clr = 1'b1;
        cycle();
        chk("s4.clr", 32'(b3), 32'd0);

        clr = 1'b0; load = 1'b0; up_down = 1'b1;
        repeat (5) cycle();
        chk("s5.pre", 32'(b3), 32'd5);
        rst_n = 1'b0;
        cycle();
        chk("s5.bin", 32'(b3), 32'd0);
        chk("s5.wrap", 32'(w3_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            rst_n   = ($urandom_range(255) != 0);
            clr     = ($urandom_range(31) == 0);
            load    = ($urandom_range(15) == 0);
            en      = ($urandom_range(3) != 0);
            up_down = ($urandom_range(1) != 0);
            lg      = 4'($urandom_range(15));
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
